// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the round-robin scheduled 8:1 mux.
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Requester i drives mux input a..h, which is selected by the reversed code.
  function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
    return 3'd7 - idx;
  endfunction

endpackage

// File: rtl/mux_rr_sched_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] winner,
  output logic       any_req
);

  logic [15:0] dbl_s;
  logic [3:0]  start_s;
  logic [7:0]  rot_s;
  logic [2:0]  off_s;

  // Rotate so bit 0 of rot_s is requester ptr+1, then take the lowest set bit.
  always_comb begin
    dbl_s   = {req, req};
    start_s = {1'b0, ptr} + 4'd1;
    rot_s   = dbl_s[start_s +: 8];
    casez (rot_s)
      8'b???????1: off_s = 3'd0;
      8'b??????10: off_s = 3'd1;
      8'b?????100: off_s = 3'd2;
      8'b????1000: off_s = 3'd3;
      8'b???10000: off_s = 3'd4;
      8'b??100000: off_s = 3'd5;
      8'b?1000000: off_s = 3'd6;
      8'b10000000: off_s = 3'd7;
      default:     off_s = 3'd0;
    endcase
    winner  = ptr + 3'd1 + off_s;
    any_req = |req;
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin arbiter driving an 8:1 one-bit mux with beat-limited, registered grants.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic [7:0] din,
  input  logic       ready,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] sel,
  output logic       y,
  output logic       y_valid
);

  state_t           state_r, state_s;
  logic [2:0]       owner_r, owner_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       gnt_r, gnt_s;
  logic             gnt_valid_r, gnt_valid_s;
  logic [2:0]       sel_r, sel_s;
  logic             y_r, y_s;
  logic             y_valid_r, y_valid_s;

  logic [2:0]       pick_ptr_s;
  logic [2:0]       winner_s;
  logic             any_s;
  logic             accept_s;
  logic             release_s;

  // While busy the current owner becomes lowest priority for the hand-over.
  assign pick_ptr_s = (state_r == ST_BUSY) ? owner_r : ptr_r;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (pick_ptr_s),
    .winner  (winner_s),
    .any_req (any_s)
  );

  assign accept_s  = gnt_valid_r & ready;
  assign release_s = (state_r == ST_BUSY) &
                     ((accept_s & last[owner_r]) |
                      (accept_s & (cnt_r == CNT_W'(MAX_BEATS - 1))) |
                      ~req[owner_r]);

  // Next-state, grant and data-capture logic.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    gnt_s       = gnt_r;
    gnt_valid_s = gnt_valid_r;
    sel_s       = sel_r;
    y_s         = y_r;
    y_valid_s   = 1'b0;

    if (accept_s) begin
      y_s       = din[owner_r];
      y_valid_s = 1'b1;
    end else begin
      y_s       = y_r;
      y_valid_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_s     = ST_BUSY;
          owner_s     = winner_s;
          cnt_s       = {CNT_W{1'b0}};
          gnt_s       = 8'h01 << winner_s;
          gnt_valid_s = 1'b1;
          sel_s       = idx_to_sel(winner_s);
        end else begin
          state_s     = ST_IDLE;
          gnt_s       = 8'h00;
          gnt_valid_s = 1'b0;
          sel_s       = 3'd0;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          ptr_s = owner_r;
          if (any_s) begin
            state_s     = ST_BUSY;
            owner_s     = winner_s;
            cnt_s       = {CNT_W{1'b0}};
            gnt_s       = 8'h01 << winner_s;
            gnt_valid_s = 1'b1;
            sel_s       = idx_to_sel(winner_s);
          end else begin
            state_s     = ST_IDLE;
            cnt_s       = {CNT_W{1'b0}};
            gnt_s       = 8'h00;
            gnt_valid_s = 1'b0;
            sel_s       = 3'd0;
          end
        end else if (accept_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = {CNT_W{1'b0}};
        gnt_s       = 8'h00;
        gnt_valid_s = 1'b0;
        sel_s       = 3'd0;
      end
    endcase
  end

  // State and output registers; ptr resets to 7 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= 3'd0;
      ptr_r       <= 3'd7;
      cnt_r       <= {CNT_W{1'b0}};
      gnt_r       <= 8'h00;
      gnt_valid_r <= 1'b0;
      sel_r       <= 3'd0;
      y_r         <= 1'b0;
      y_valid_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= gnt_valid_s;
      sel_r       <= sel_s;
      y_r         <= y_s;
      y_valid_r   <= y_valid_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign sel       = sel_r;
  assign y         = y_r;
  assign y_valid   = y_valid_r;

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 Parameter: MAX_BEATS, 16, max accepted beats per grant before forced release (range 1..255).
REQ-002 Parameter: CNT_W, 8, beat counter width.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  8  request per requester; index 0..7 = mux inputs a..h.
REQ-006 Port: last  input  8  per-requester final-beat flag, sampled only for the current owner.
REQ-007 Port: din  input  8  per-requester data bit.
REQ-008 Port: ready  input  1  downstream accepts a beat this cycle.
REQ-009 Port: gnt  output  8  one-hot grant; all-zero when idle.
REQ-010 Port: gnt_valid  output  1  a grant is active.
REQ-011 Port: sel  output  3  mux select for the owner; requester i drives sel = 7-i.
REQ-012 Port: y  output  1  registered data bit of the last accepted beat.
REQ-013 Port: y_valid  output  1  one-cycle pulse, y updated.

Function
REQ-014 States: IDLE, BUSY; gnt, gnt_valid, sel are registered.
REQ-015 IDLE with req==0: remain IDLE, gnt=0, gnt_valid=0.
REQ-016 IDLE with any req bit set at edge N: at edge N the winner is registered; gnt/gnt_valid/sel valid in cycle N+1 (one-cycle latency); state BUSY.
REQ-017 Winner: round-robin, first set req bit scanning from ptr+1 upward modulo 8; ptr = index of previous owner.
REQ-018 Beat accepted when gnt_valid && ready; beat counter increments by 1 on each accept, cleared on every new grant.
REQ-019 Release when, in BUSY: (accept && last[owner]) OR (accept && count==MAX_BEATS-1) OR req[owner]==0.
REQ-020 On release, ptr <= owner; if any other req bit set, the next winner is granted at the same edge (no idle bubble), owner gets lowest priority.
REQ-021 On release with only req[owner] still set, owner is re-granted with counter cleared; with req==0, go IDLE.
REQ-022 req[owner] dropping without accept: release, no beat counted, y_valid stays 0.
REQ-023 ready without gnt_valid: ignored.
REQ-024 On accept: y <= din[owner], y_valid=1 the following cycle; otherwise y holds and y_valid=0.
REQ-025 gnt is always one-hot or zero; gnt_valid == |gnt; sel consistent with gnt in the same cycle.
REQ-026 last[] of non-owners and din[] of non-owners never affect state.

Reset
REQ-027 rst asserted: state IDLE, gnt=0, gnt_valid=0, sel=3'b000, ptr=7 (requester 0 highest priority), counter=0, y=0, y_valid=0, immediately, independent of clk.
REQ-028 rst mid-grant discards the grant and beat count; first arbitration after release follows REQ-016.

Structure
REQ-029 Package mux_sched_pkg: state enum, N_REQ=8, SEL_W=3, constant function idx_to_sel (7-i).
REQ-030 One sub-module rr_pick8: combinational, inputs req[7:0] and ptr[2:0], outputs winner index and any-flag.
REQ-031 Target 120-400 RTL lines in total.

Verification
REQ-032 Reset then req=8'h01 -> gnt=8'h01, sel=3'b111 next cycle; ready=1, last=8'h01, din[0]=1 on first beat -> y=1, y_valid pulse, return to IDLE.
REQ-033 req=8'hFF held, each owner asserts last on first beat, ready=1 -> grants 0,1,...,7,0 in order with no idle cycle between grants.
REQ-034 Owner 3 alone, ready=1, last never set, MAX_BEATS=16 -> exactly 16 y_valid pulses, then re-grant to 3 with counter cleared.
REQ-035 Owner 2 with req=8'h24, owner drops req[2] with ready=0 -> next cycle gnt=8'h20, sel=3'b010, no y_valid.
REQ-036 rst pulsed mid-burst (owner 5, count 7) -> outputs zero asynchronously; after rst with req=8'hA0 -> gnt=8'h20 first.
